// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Purpose : Constants and helpers shared by the 16-point FFT output reorder
//           logic (frame size, address width, bit-reversal of a bin index).
// Ports   : none (package).
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_POINTS = 16;
  localparam int FFT_LOG2   = 4;

  typedef logic [FFT_LOG2-1:0] bin_t;

  // Reverse the 4 bits of a bin index (0b0001 -> 0b1000).
  function automatic bin_t bitrev4(input bin_t a);
    bin_t r;
    for (int i = 0; i < FFT_LOG2; i++) begin
      r[i] = a[FFT_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// -----------------------------------------------------------------------------
// fft_bank_ram
// Purpose : Two 16-entry sample banks held in one 32-deep memory. The address
//           MSB selects the bank. One write port, one registered read port.
// Ports   : clk     - clock
//           rst_n   - asynchronous active-low reset (read register only)
//           i_we    - write enable
//           i_waddr - write address {bank, entry}
//           i_wdata - write data
//           i_re    - read enable; the read register holds when low
//           i_raddr - read address {bank, entry}
//           o_rdata - registered read data
// -----------------------------------------------------------------------------
module fft_bank_ram
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [FFT_LOG2:0]     i_waddr,
  input  logic [W-1:0]          i_wdata,
  input  logic                  i_re,
  input  logic [FFT_LOG2:0]     i_raddr,
  output logic [W-1:0]          o_rdata
);

  logic [W-1:0] r_mem [0:2*FFT_POINTS-1];

  // Storage itself carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register doubles as the block's output data register, so it is
  // cleared on reset and holds its value while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/fft_reorder16.sv
// -----------------------------------------------------------------------------
// fft_reorder16
// Purpose : Converts bit-reversed 16-point FFT output into natural frequency
//           order using two ping-pong banks. Samples pass unmodified.
// Ports   : clk        - clock
//           clear      - asynchronous active-low reset
//           in_valid   - input sample strobe (bit-reversed order)
//           in_r/in_im - input sample, N-bit two's complement
//           out_ready  - consumer accepts the current output
//           out_valid  - output qualifier
//           out_r/out_im - output sample in natural order
//           out_index  - natural bin number of the output
//           frame_done - high with the bin-15 output beat
//           overflow   - sticky: an input sample was dropped
//           mag        - |out_r|+|out_im| (only with FFT_REORDER_MAG_EN)
// Option  : define FFT_REORDER_MAG_EN to add the mag output.
// -----------------------------------------------------------------------------
module fft_reorder16
  import fft_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [N-1:0]        in_r,
  input  logic [N-1:0]        in_im,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [N-1:0]        out_r,
  output logic [N-1:0]        out_im,
  output logic [FFT_LOG2-1:0] out_index,
  output logic                frame_done,
`ifdef FFT_REORDER_MAG_EN
  output logic [N:0]          mag,
`endif
  output logic                overflow
);

`ifdef FFT_REORDER_MAG_EN
  // Magnitude is computed on the write side and stored next to the sample, so
  // it leaves the RAM read register in the same cycle as out_r/out_im.
  localparam int DW = 3*N + 1;
`else
  localparam int DW = 2*N;
`endif

  logic                r_wbank;
  logic [FFT_LOG2-1:0] r_wcnt;
  logic [1:0]          r_full;
  logic                r_rbank;
  logic [FFT_LOG2-1:0] r_rcnt;
  logic                r_out_valid;
  logic                r_frame_done;
  logic                r_overflow;

  logic                w_fire;
  logic                w_release;
  logic                w_accept;
  logic                w_wrap;
  logic                w_other_bank;
  logic                w_re;
  logic [FFT_LOG2:0]   w_raddr;
  logic                w_rbank_next;
  logic [FFT_LOG2-1:0] w_rcnt_next;
  logic                w_valid_next;
  logic [1:0]          w_full_next;
  logic [DW-1:0]       w_wdata;
  logic [DW-1:0]       w_rdata;

  assign w_fire       = r_out_valid & out_ready;
  assign w_release    = w_fire & (r_rcnt == 4'd15);
  assign w_other_bank = ~r_rbank;
  // A bank freed on this edge can take a write on the same edge.
  assign w_accept     = in_valid & (~r_full[r_wbank] | (w_release & (r_rbank == r_wbank)));
  assign w_wrap       = w_accept & (r_wcnt == 4'd15);

`ifdef FFT_REORDER_MAG_EN
  logic [N-1:0] w_abs_r;
  logic [N-1:0] w_abs_im;
  logic [N:0]   w_mag;
  // Read as unsigned N bits, the negation of -2^(N-1) is exactly 2^(N-1).
  assign w_abs_r  = in_r[N-1]  ? (~in_r  + 1'b1) : in_r;
  assign w_abs_im = in_im[N-1] ? (~in_im + 1'b1) : in_im;
  assign w_mag    = {1'b0, w_abs_r} + {1'b0, w_abs_im};
  assign w_wdata  = {w_mag, in_r, in_im};
  assign mag      = w_rdata[3*N:2*N];
`else
  assign w_wdata  = {in_r, in_im};
`endif

  // Read-side sequencing: load the next bin when the output slot is empty or
  // is being consumed; otherwise the RAM read register holds.
  always_comb begin
    w_re         = 1'b0;
    w_raddr      = '0;
    w_rbank_next = r_rbank;
    w_rcnt_next  = r_rcnt;
    w_valid_next = r_out_valid;
    if (!r_out_valid) begin
      if (r_full[r_rbank]) begin
        w_re         = 1'b1;
        w_raddr      = {r_rbank, 4'd0};
        w_rcnt_next  = 4'd0;
        w_valid_next = 1'b1;
      end
    end else if (w_fire) begin
      if (!w_release) begin
        w_re        = 1'b1;
        w_rcnt_next = r_rcnt + 4'd1;
        w_raddr     = {r_rbank, w_rcnt_next};
      end else begin
        // Bank finished: move to the other bank, continuing at once if full.
        w_rbank_next = w_other_bank;
        w_rcnt_next  = 4'd0;
        if (r_full[w_other_bank]) begin
          w_re         = 1'b1;
          w_raddr      = {w_other_bank, 4'd0};
          w_valid_next = 1'b1;
        end else begin
          w_valid_next = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_full_next = r_full;
    if (w_release) w_full_next[r_rbank] = 1'b0;
    if (w_wrap)    w_full_next[r_wbank] = 1'b1;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_wbank      <= 1'b0;
      r_wcnt       <= '0;
      r_full       <= '0;
      r_rbank      <= 1'b0;
      r_rcnt       <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_full       <= w_full_next;
      r_rbank      <= w_rbank_next;
      r_rcnt       <= w_rcnt_next;
      r_out_valid  <= w_valid_next;
      r_frame_done <= w_valid_next & (w_rcnt_next == 4'd15);
      if (w_accept) begin
        r_wcnt <= r_wcnt + 4'd1;
        if (w_wrap) r_wbank <= ~r_wbank;
      end
      if (in_valid && !w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  fft_bank_ram #(.W(DW)) u_ram (
    .clk     (clk),
    .rst_n   (clear),
    .i_we    (w_accept),
    .i_waddr ({r_wbank, bitrev4(r_wcnt)}),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign out_r      = w_rdata[2*N-1:N];
  assign out_im     = w_rdata[N-1:0];
  assign out_valid  = r_out_valid;
  assign out_index  = r_rcnt;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fft_reorder16.sv
// -----------------------------------------------------------------------------
// tb_fft_reorder16
// Purpose : Self-checking bench for fft_reorder16 (N=8). Each output beat is
//           logged at the falling edge and compared against a hand-written
//           natural-order table. Define FFT_REORDER_MAG_EN to also cover mag.
// -----------------------------------------------------------------------------
module tb_fft_reorder16;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_r = '0;
  logic [N-1:0] in_im = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [N-1:0] out_r;
  logic [N-1:0] out_im;
  logic [3:0]   out_index;
  logic         frame_done;
  logic         overflow;
`ifdef FFT_REORDER_MAG_EN
  logic [N:0]   mag;
`endif

  fft_reorder16 #(.N(N)) dut (
    .clk        (clk),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_r       (in_r),
    .in_im      (in_im),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_r      (out_r),
    .out_im     (out_im),
    .out_index  (out_index),
    .frame_done (frame_done),
`ifdef FFT_REORDER_MAG_EN
    .mag        (mag),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] im;
    logic [3:0]   idx;
    logic         fd;
    int           stamp;
  } beat_t;

  typedef struct {
    logic [N-1:0] r;    // value of in_r offset expected at this bin
    logic [3:0]   idx;
    logic         fd;
  } vec_t;

  beat_t beats[$];
  vec_t  tbl[16];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  // Beat logger: a beat completes at the next rising edge when valid&ready.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clear && out_valid && out_ready) begin
      beats.push_back('{r: out_r, im: out_im, idx: out_index, fd: frame_done, stamp: cyc});
      $display("beat %0d: cycle=%0d index=%0d r=%0d im=%0d frame_done=%0b",
               beats.size() - 1, cyc, out_index, out_r, out_im, frame_done);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives 16 samples on consecutive cycles: in_r=base+k, in_im=255-(base+k).
  task automatic send_frame(input logic [N-1:0] base);
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_r     = N'(base + k);
      in_im    = N'(8'hFF - N'(base + k));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int b = 0;
    while (beats.size() < n && b < 600) begin
      @(negedge clk);
      b++;
    end
    chk(name, 32'(beats.size() >= n), 32'd1);
  endtask

  task automatic wait_index(input logic [3:0] idx, input string name);
    int b = 0;
    @(negedge clk);
    while (!(out_valid && out_index == idx) && b < 600) begin
      @(negedge clk);
      b++;
    end
    chk(name, 32'(out_valid && out_index == idx), 32'd1);
  endtask

  task automatic check_frame(input int start, input logic [N-1:0] base, input string name);
    logic [N-1:0] er;
    for (int i = 0; i < 16; i++) begin
      if (start + i >= beats.size()) break;
      er = N'(base + tbl[i].r);
      chk($sformatf("%s r[%0d]", name, i),   32'(beats[start+i].r),   32'(er));
      chk($sformatf("%s im[%0d]", name, i),  32'(beats[start+i].im),  32'(N'(8'hFF - er)));
      chk($sformatf("%s idx[%0d]", name, i), 32'(beats[start+i].idx), 32'(tbl[i].idx));
      chk($sformatf("%s fd[%0d]", name, i),  32'(beats[start+i].fd),  32'(tbl[i].fd));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " out_valid"},  32'(out_valid),  32'd0);
    chk({name, " out_r"},      32'(out_r),      32'd0);
    chk({name, " out_im"},     32'(out_im),     32'd0);
    chk({name, " out_index"},  32'(out_index),  32'd0);
    chk({name, " frame_done"}, 32'(frame_done), 32'd0);
    chk({name, " overflow"},   32'(overflow),   32'd0);
  endtask

  initial begin
    logic [N-1:0] rev_vals [16];
    rev_vals = '{8'd0, 8'd8, 8'd4, 8'd12, 8'd2, 8'd10, 8'd6, 8'd14,
                 8'd1, 8'd9, 8'd5, 8'd13, 8'd3, 8'd11, 8'd7, 8'd15};
    for (int i = 0; i < 16; i++) begin
      tbl[i].r   = rev_vals[i];
      tbl[i].idx = 4'(i);
      tbl[i].fd  = (i == 15);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1;

    // Single frame, natural-order output and first-beat latency
    out_ready = 1'b1;
    beats.delete();
    send_frame(8'd0);
    @(negedge clk);
    chk("t1 valid before read edge", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1 valid after read edge", 32'(out_valid), 32'd1);
    wait_beats(16, "t1 beats arrive");
    repeat (4) @(negedge clk);
    chk("t1 beat count", 32'(beats.size()), 32'd16);
    check_frame(0, 8'd0, "t1");
    @(posedge clk); #1;

    // Two back-to-back frames: 32 gapless beats
    beats.delete();
    send_frame(8'd16);
    send_frame(8'd32);
    wait_beats(32, "t2 beats arrive");
    repeat (4) @(negedge clk);
    chk("t2 beat count", 32'(beats.size()), 32'd32);
    for (int i = 1; i < 32 && i < beats.size(); i++) begin
      chk($sformatf("t2 gap[%0d]", i), 32'(beats[i].stamp - beats[i-1].stamp), 32'd1);
    end
    check_frame(0, 8'd16, "t2 f1");
    check_frame(16, 8'd32, "t2 f2");
    chk("t2 overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;

    // Stalled consumer: third frame dropped, then release-edge write accepted
    out_ready = 1'b0;
    beats.delete();
    send_frame(8'd0);
    send_frame(8'd16);
    send_frame(8'd32);
    @(negedge clk);
    chk("t3 overflow", 32'(overflow), 32'd1);
    chk("t3 no beats while stalled", 32'(beats.size()), 32'd0);
    chk("t3 holding bin 0", 32'(out_valid && out_index == 4'd0), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_r      = 8'd48;
    in_im     = 8'd255 - 8'd48;
    out_ready = 1'b1;
    wait_index(4'd15, "t3 reach bin 15");
    @(posedge clk); #1;   // bank released and sample 48 written on this edge
    for (int k = 1; k < 16; k++) begin
      in_r  = N'(48 + k);
      in_im = N'(8'hFF - N'(48 + k));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_beats(48, "t3 beats arrive");
    repeat (4) @(negedge clk);
    chk("t3 beat count", 32'(beats.size()), 32'd48);
    check_frame(0, 8'd0, "t3 f1");
    check_frame(16, 8'd16, "t3 f2");
    check_frame(32, 8'd48, "t3 f4");
    @(posedge clk); #1;

    // Three-cycle stall at bin 5
    beats.delete();
    out_ready = 1'b1;
    send_frame(8'd64);
    wait_index(4'd4, "t4 reach bin 4");
    @(posedge clk); #1 out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("t4 hold valid %0d", s), 32'(out_valid),  32'd1);
      chk($sformatf("t4 hold index %0d", s), 32'(out_index),  32'd5);
      chk($sformatf("t4 hold r %0d", s),     32'(out_r),      32'd74);
      chk($sformatf("t4 hold im %0d", s),    32'(out_im),     32'd181);
      chk($sformatf("t4 hold fd %0d", s),    32'(frame_done), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_beats(16, "t4 beats arrive");
    repeat (4) @(negedge clk);
    chk("t4 beat count", 32'(beats.size()), 32'd16);
    check_frame(0, 8'd64, "t4");
    @(posedge clk); #1;

    // Reset after 7 inputs, then one clean frame
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_r     = N'(100 + k);
      in_im    = N'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("t5 mid reset");
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1;
    beats.delete();
    send_frame(8'd128);
    wait_beats(16, "t5 beats arrive");
    repeat (4) @(negedge clk);
    chk("t5 beat count", 32'(beats.size()), 32'd16);
    check_frame(0, 8'd128, "t5");
    @(posedge clk); #1;

`ifdef FFT_REORDER_MAG_EN
    // Magnitude of the most negative value on both parts
    beats.delete();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_r     = (k == 0) ? 8'h80 : 8'd0;
      in_im    = (k == 0) ? 8'h80 : 8'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_index(4'd0, "mag reach bin 0");
    chk("mag bin 0", 32'(mag), 32'd256);
    repeat (20) @(posedge clk);
    #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
